quadrature_encoder_emulator: RTL and testbench

//  Generates quadrature encoder signals (A, B, I) from a commanded step period and direction.
//  It is the transmit side of encoder_reader. It drives the encoder inputs of the motor

---
 rtl/motor_pkg.sv | 27 ++
 rtl/enc_step_timer.sv | 45 ++++
 rtl/quadrature_encoder_emulator.sv | 84 ++++++++
 tb/tb_quadrature_encoder_emulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared quadrature definitions for the encoder emulator and encoder reader.
// quad_state_t encodes {A,B} directly, so a state can be split straight onto the pins.
package motor_pkg;

    typedef enum logic [1:0] {
        Q_00 = 2'b00,
        Q_10 = 2'b10,
        Q_11 = 2'b11,
        Q_01 = 2'b01
    } quad_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Gray sequence: adjacent positions differ in exactly one of A/B.
    function automatic quad_state_t pos_to_quad(input logic [1:0] pos);
        quad_state_t q;
        case (pos)
            2'd0:    q = Q_00;
            2'd1:    q = Q_10;
            2'd2:    q = Q_11;
            default: q = Q_01;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/enc_step_timer.sv
// Step-period down-counter: ticks once every i_period cycles while enabled.
// The tick is combinational on the cycle the counter sits at zero.
module enc_step_timer #(
    parameter int K_PERIOD_RES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_load,
    input  logic [K_PERIOD_RES-1:0] i_period,
    output logic                    o_tick
);

    localparam logic [K_PERIOD_RES-1:0] CNT_ONE = K_PERIOD_RES'(1);

    logic [K_PERIOD_RES-1:0] count_q, count_d;
    logic [K_PERIOD_RES-1:0] reload;
    logic                    period_zero;

    always_comb begin
        period_zero = (i_period == '0);
        reload      = period_zero ? '0 : (i_period - CNT_ONE);
        o_tick      = i_enable && !period_zero && (count_q == '0);
        count_d     = count_q;
        // A load restarts the period even though its coincident step is dropped upstream.
        if (i_load) begin
            count_d = reload;
        end else if (!i_enable || period_zero) begin
            count_d = '0;
        end else if (count_q == '0) begin
            count_d = reload;
        end else begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature encoder emulator: turns a step period and direction into A/B/I,
// tracking absolute position modulo K_CPR with one index state per revolution.
module quadrature_encoder_emulator
    import motor_pkg::*;
#(
    parameter  int K_PERIOD_RES = 16,
    parameter  int K_CPR        = 1024,
    localparam int K_POS_W      = $clog2(K_CPR)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_direction,
    input  logic [K_PERIOD_RES-1:0] i_period,
    input  logic                    i_index_en,
    input  logic                    i_load,
    input  logic [K_POS_W-1:0]      i_load_pos,
    output logic                    o_enc_a,
    output logic                    o_enc_b,
    output logic                    o_enc_i,
    output logic [K_POS_W-1:0]      o_position,
    output logic                    o_step
);

    localparam logic [K_POS_W-1:0] POS_ONE = K_POS_W'(1);

    logic               tick;
    logic [K_POS_W-1:0] pos_q, pos_d;
    logic               a_q, a_d, b_q, b_d;
    logic               idx_q, idx_d;
    logic               step_q, step_d;
    quad_state_t        quad;

    enc_step_timer #(
        .K_PERIOD_RES(K_PERIOD_RES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_enable),
        .i_load   (i_load),
        .i_period (i_period),
        .o_tick   (tick)
    );

    // K_CPR is a power of two, so plain wrap-around arithmetic gives the modulo.
    always_comb begin
        step_d = tick && !i_load;
        pos_d  = pos_q;
        if (i_load) begin
            pos_d = i_load_pos;
        end else if (step_d) begin
            pos_d = (i_direction == DIR_REV) ? (pos_q - POS_ONE) : (pos_q + POS_ONE);
        end
        quad       = pos_to_quad(pos_d[1:0]);
        {a_d, b_d} = quad;
        idx_d      = idx_q;
        if (i_enable || i_load) begin
            idx_d = i_index_en && (pos_d == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pos_q  <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            idx_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            a_q    <= a_d;
            b_q    <= b_d;
            idx_q  <= idx_d;
            step_q <= step_d;
        end
    end

    assign o_enc_a    = a_q;
    assign o_enc_b    = b_q;
    assign o_enc_i    = idx_q;
    assign o_position = pos_q;
    assign o_step     = step_q;

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Bench for quadrature_encoder_emulator: two instances (1024 and 8 counts per rev)
// share stimulus and are compared every cycle against a behavioural model.
module tb_quadrature_encoder_emulator;

    typedef struct {
        int   pos;
        int   cnt;
        logic a;
        logic b;
        logic i;
        logic step;
    } model_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        dir;
    logic [15:0] per;
    logic        idx_en;
    logic        load;
    logic [9:0]  load_pos;

    logic       a1, b1, i1, s1;
    logic [9:0] p1;
    logic       a8, b8, i8, s8;
    logic [2:0] p8;

    int checks = 0;
    int errors = 0;

    model_t m1, m8;
    logic [1:0] ab_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] prev_ab1, prev_ab8;
    int dut_steps, model_steps, icount;

    quadrature_encoder_emulator #(.K_PERIOD_RES(16), .K_CPR(1024)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_direction(dir), .i_period(per),
        .i_index_en(idx_en), .i_load(load), .i_load_pos(load_pos),
        .o_enc_a(a1), .o_enc_b(b1), .o_enc_i(i1), .o_position(p1), .o_step(s1)
    );

    quadrature_encoder_emulator #(.K_PERIOD_RES(16), .K_CPR(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_direction(dir), .i_period(per),
        .i_index_en(idx_en), .i_load(load), .i_load_pos(load_pos[2:0]),
        .o_enc_a(a8), .o_enc_b(b8), .o_enc_i(i8), .o_position(p8), .o_step(s8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: cnt is the number of cycles remaining until the next step is due.
    function automatic model_t model_next(input model_t m, input int cpr);
        model_t n;
        n = m;
        n.step = 1'b0;
        if (rst) begin
            n.pos = 0; n.cnt = 0; n.a = 1'b0; n.b = 1'b0; n.i = 1'b0;
            return n;
        end
        if (load) begin
            n.pos = int'(load_pos) % cpr;
            n.cnt = (per == 0) ? 0 : int'(per) - 1;
        end else if (!en || per == 0) begin
            n.cnt = 0;
        end else if (m.cnt == 0) begin
            n.step = 1'b1;
            n.cnt  = int'(per) - 1;
            n.pos  = dir ? (m.pos + cpr - 1) % cpr : (m.pos + 1) % cpr;
        end else begin
            n.cnt = m.cnt - 1;
        end
        if (en || load) n.i = idx_en && (n.pos == 0);
        {n.a, n.b} = ab_tbl[n.pos % 4];
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_cycle();
        bit jump;
        jump = rst || load;
        @(posedge clk);
        m1 = model_next(m1, 1024);
        m8 = model_next(m8, 8);
        if (m1.step) model_steps++;
        #1;
        if (s1) dut_steps++;
        chk("pos1", 32'(p1), m1.pos);
        chk("ab1", {a1, b1}, {m1.a, m1.b});
        chk("idx1", i1, m1.i);
        chk("step1", s1, m1.step);
        chk("pos8", 32'(p8), m8.pos);
        chk("ab8", {a8, b8}, {m8.a, m8.b});
        chk("idx8", i8, m8.i);
        chk("step8", s8, m8.step);
        if (!jump && {a1, b1} != prev_ab1) chk("ab1_one_bit", $countones({a1, b1} ^ prev_ab1), 1);
        if (!jump && {a8, b8} != prev_ab8) chk("ab8_one_bit", $countones({a8, b8} ^ prev_ab8), 1);
        prev_ab1 = {a1, b1};
        prev_ab8 = {a8, b8};
    endtask

    // Parks both instances at a position with the counter cleared and emulator stopped.
    task automatic park_at(input logic [9:0] pos);
        en = 1'b0; per = 16'd0; load = 1'b1; load_pos = pos;
        tick_cycle();
        load = 1'b0;
    endtask

    initial begin
        logic [1:0] fwd_ab [4];
        fwd_ab = '{2'b10, 2'b11, 2'b01, 2'b00};
        rst = 1'b1; en = 1'b1; dir = 1'b0; per = 16'd0; idx_en = 1'b1;
        load = 1'b0; load_pos = 10'd0;
        m1 = '{pos: 0, cnt: 0, a: 1'b0, b: 1'b0, i: 1'b0, step: 1'b0};
        m8 = m1;
        prev_ab1 = 2'b00; prev_ab8 = 2'b00;
        dut_steps = 0; model_steps = 0;

        // Reset held three cycles, then index rises one cycle after release
        repeat (3) tick_cycle();
        chk("rst_pos", 32'(p1), 0);
        chk("rst_ab", {a1, b1}, 2'b00);
        chk("rst_idx", i1, 0);
        chk("rst_step", s1, 0);
        rst = 1'b0;
        tick_cycle();
        chk("idx_after_rst", i1, 1);
        chk("idx8_after_rst", i8, 1);

        // Forward at period 4
        park_at(10'd0);
        per = 16'd4; dir = 1'b0; idx_en = 1'b0; en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                tick_cycle();
                chk("fwd4_pos", 32'(p1), k);
                chk("fwd4_ab", {a1, b1}, fwd_ab[k-1]);
                chk("fwd4_step", s1, (j == 0) ? 1 : 0);
            end
        end

        // Reverse at period 2 from 0 wraps to the top
        park_at(10'd0);
        per = 16'd2; dir = 1'b1; en = 1'b1;
        tick_cycle();
        chk("rev_wrap_pos", 32'(p1), 1023);
        chk("rev_wrap_ab", {a1, b1}, 2'b01);
        tick_cycle();
        chk("rev_hold_step", s1, 0);
        tick_cycle();
        chk("rev_pos2", 32'(p1), 1022);
        chk("rev_ab2", {a1, b1}, 2'b11);

        // Index on the 8-count instance: 3 cycles per 24-cycle revolution
        park_at(10'd0);
        per = 16'd3; dir = 1'b0; idx_en = 1'b1; en = 1'b1;
        icount = 0;
        repeat (48) begin
            tick_cycle();
            if (i8) begin
                icount++;
                chk("idx8_at_zero", 32'(p8), 0);
            end
        end
        chk("idx8_cycles", icount, 6);
        idx_en = 1'b0;
        icount = 0;
        repeat (48) begin
            tick_cycle();
            if (i8) icount++;
        end
        chk("idx8_disabled", icount, 0);

        // Direction flip between steps, then load coincident with a step
        park_at(10'd0);
        per = 16'd2; dir = 1'b0; en = 1'b1;
        repeat (9) tick_cycle();
        chk("flip_pos5", 32'(p1), 5);
        chk("flip_ab5", {a1, b1}, 2'b10);
        dir = 1'b1;
        tick_cycle();
        tick_cycle();
        chk("flip_pos4", 32'(p1), 4);
        chk("flip_ab4", {a1, b1}, 2'b00);
        chk("flip_step", s1, 1);
        tick_cycle();
        load = 1'b1; load_pos = 10'd200;
        tick_cycle();
        load = 1'b0;
        chk("load_pos", 32'(p1), 200);
        chk("load_step_drop", s1, 0);
        tick_cycle();
        tick_cycle();
        chk("after_load_pos", 32'(p1), 199);
        chk("after_load_step", s1, 1);

        // Stopped: period 0 gives no steps
        dut_steps = 0; model_steps = 0;
        per = 16'd0; en = 1'b1;
        repeat (50) tick_cycle();
        chk("period0_steps", dut_steps, 0);

        // Randomised run with occasional loads and resets
        dut_steps = 0; model_steps = 0;
        per = 16'd1; dir = 1'b0; en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 499) == 0);
            load = ($urandom_range(0, 199) == 0);
            load_pos = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 19) == 0) per = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) idx_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) en = ($urandom_range(0, 3) != 0);
            tick_cycle();
        end
        rst = 1'b0; load = 1'b0;
        chk("random_step_count", dut_steps, model_steps);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
